// File: rtl/page_access_sampler.sv
// -----------------------------------------------------------------------------
// page_access_sampler
//
// Snoops the AXI read/write address handshakes, turns each access into a page
// address, rate-samples the accesses and buffers the sampled page addresses.
// It streams them to the page hot tracker. After every MIG_TH delivered
// addresses it raises a MIG query. A FLUSH query can be requested with
// flush_req.
//
// Ports
//   clk, rstn                       clock, asynchronous active-low reset
//   ar_addr/ar_valid/ar_ready       snooped read address handshake
//   aw_addr/aw_valid/aw_ready       snooped write address handshake
//   cfg_enable                      sampling enable
//   cfg_track_writes                include write accesses
//   cfg_sample_log2                 sample 1 of every 2^n events
//   flush_req                       single-cycle FLUSH query request
//   out_addr/out_valid/out_ready    page-address stream to the tracker
//   query_en/query_cmd/query_ready  tracker query handshake (0 IDLE, 1 MIG, 2 FLUSH)
//   stat_sent_cnt                   addresses delivered (saturating)
//   stat_drop_cnt                   sampled addresses dropped on full (saturating)
// -----------------------------------------------------------------------------
module page_access_sampler #(
    parameter int AXI_ADDR_W  = 52,
    parameter int PAGE_SHIFT  = 12,
    parameter int ADDR_SIZE   = 28,
    parameter int FIFO_DEPTH  = 8,
    parameter int SAMPLE_BITS = 4,
    parameter int MIG_TH      = 450,
    parameter int CMD_WIDTH   = 4,
    parameter int CNT_SIZE    = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [AXI_ADDR_W-1:0]  ar_addr,
    input  logic                   ar_valid,
    input  logic                   ar_ready,
    input  logic [AXI_ADDR_W-1:0]  aw_addr,
    input  logic                   aw_valid,
    input  logic                   aw_ready,
    input  logic                   cfg_enable,
    input  logic                   cfg_track_writes,
    input  logic [SAMPLE_BITS-1:0] cfg_sample_log2,
    input  logic                   flush_req,
    output logic [ADDR_SIZE-1:0]   out_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   query_en,
    output logic [CMD_WIDTH-1:0]   query_cmd,
    input  logic                   query_ready,
    output logic [CNT_SIZE-1:0]    stat_sent_cnt,
    output logic [CNT_SIZE-1:0]    stat_drop_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = $clog2(MIG_TH + 1);

    localparam logic [CW-1:0]        DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [EW-1:0]        EPOCH_LAST = EW'(MIG_TH - 1);
    localparam logic [CMD_WIDTH-1:0] CMD_IDLE   = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] CMD_MIG    = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] CMD_FLUSH  = CMD_WIDTH'(2);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        QWAIT = 2'd1,
        QDONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_reg, state_next;
    logic [CMD_WIDTH-1:0]   qcmd_reg, qcmd_next;
    logic [15:0]            ev_cnt_reg, ev_cnt_next;
    logic [CW-1:0]          count_reg, count_next;
    logic [PW-1:0]          rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]          wr_ptr_reg, wr_ptr_next;
    logic [EW-1:0]          epoch_reg, epoch_next;
    logic [CNT_SIZE-1:0]    sent_reg, sent_next;
    logic [CNT_SIZE-1:0]    drop_reg, drop_next;
    logic [ADDR_SIZE-1:0]   out_addr_reg, out_addr_next;
    logic                   out_valid_reg, out_valid_next;
    logic                   query_en_reg, query_en_next;
    logic [CMD_WIDTH-1:0]   query_cmd_reg, query_cmd_next;

    logic [ADDR_SIZE-1:0]   mem [FIFO_DEPTH];

    // Only the page field of the snooped addresses matters; the rest is
    // folded here so the unused bits are visibly intentional.
    logic                   unused_addr_bits;
    assign unused_addr_bits = ^{ar_addr, aw_addr};

    // ------------------------------------------------------------------
    // Event detection and sampling
    // ------------------------------------------------------------------
    logic                   rd_ev, wr_ev;
    logic                   rd_sampled, wr_sampled;
    logic                   rd_push, wr_push;
    logic [1:0]             n_push, n_drop;
    logic [15:0]            sample_mask, wr_ev_val;
    logic [CW-1:0]          free_slots;
    logic [ADDR_SIZE-1:0]   rd_page, wr_page;
    logic [ADDR_SIZE-1:0]   push_data0, push_data1;

    assign rd_ev = cfg_enable & ar_valid & ar_ready;
    assign wr_ev = cfg_enable & aw_valid & aw_ready & cfg_track_writes;

    assign sample_mask = (16'd1 << cfg_sample_log2) - 16'd1;
    // The write sees k+1 only when a read consumed k in the same cycle.
    assign wr_ev_val   = ev_cnt_reg + 16'(rd_ev);
    assign rd_sampled  = rd_ev && ((ev_cnt_reg & sample_mask) == 16'd0);
    assign wr_sampled  = wr_ev && ((wr_ev_val & sample_mask) == 16'd0);
    assign ev_cnt_next = ev_cnt_reg + 16'(rd_ev) + 16'(wr_ev);

    // Free space is taken before this cycle's pop; the read has priority.
    assign free_slots = DEPTH_C - count_reg;
    assign rd_push    = rd_sampled && (free_slots != '0);
    assign wr_push    = wr_sampled && (free_slots > CW'(rd_push));
    assign n_push     = {1'b0, rd_push} + {1'b0, wr_push};
    assign n_drop     = {1'b0, rd_sampled & ~rd_push} + {1'b0, wr_sampled & ~wr_push};

    assign rd_page    = ar_addr[PAGE_SHIFT +: ADDR_SIZE];
    assign wr_page    = aw_addr[PAGE_SHIFT +: ADDR_SIZE];
    assign push_data0 = rd_push ? rd_page : wr_page;
    assign push_data1 = wr_page;

    // ------------------------------------------------------------------
    // Query state machine and FIFO bookkeeping
    // ------------------------------------------------------------------
    logic                   pop, clear, thresh_hit;
    logic [PW-1:0]          wr_base, wr_base_p1;
    logic [CNT_SIZE:0]      drop_sum;

    always_comb begin
        state_next = state_reg;
        qcmd_next  = qcmd_reg;
        epoch_next = epoch_reg;
        pop        = 1'b0;
        clear      = 1'b0;
        thresh_hit = 1'b0;

        case (state_reg)
            RUN: begin
                // out_valid_reg mirrors !empty while in RUN.
                if (out_valid_reg && out_ready) begin
                    pop = 1'b1;
                    if (epoch_reg == EPOCH_LAST) begin
                        thresh_hit = 1'b1;
                        epoch_next = '0;
                        qcmd_next  = CMD_MIG;
                        state_next = QWAIT;
                    end else begin
                        epoch_next = epoch_reg + EW'(1);
                    end
                end
                // MIG wins over a coincident flush request.
                if (flush_req && !thresh_hit) begin
                    clear      = 1'b1;
                    epoch_next = '0;
                    qcmd_next  = CMD_FLUSH;
                    state_next = QWAIT;
                end
            end
            QWAIT: begin
                if (query_ready) begin
                    state_next = QDONE;
                end
            end
            QDONE: begin
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // A flush empties the buffer; same-cycle samples land in the emptied FIFO.
    assign wr_base     = clear ? '0 : wr_ptr_reg;
    assign wr_base_p1  = wr_base + PW'(1);
    assign rd_ptr_next = clear ? '0 : rd_ptr_reg + PW'(pop);
    assign wr_ptr_next = wr_base + PW'(n_push);
    assign count_next  = (clear ? '0 : count_reg - CW'(pop)) + CW'(n_push);

    // Registered head: pick the entry that will sit at the new read pointer,
    // bypassing the array when that slot is being written this cycle.
    always_comb begin
        if (n_push != 2'd0 && wr_base == rd_ptr_next) begin
            out_addr_next = push_data0;
        end else if (n_push == 2'd2 && wr_base_p1 == rd_ptr_next) begin
            out_addr_next = push_data1;
        end else begin
            out_addr_next = mem[rd_ptr_next];
        end
    end

    assign out_valid_next = (state_next == RUN) && (count_next != '0);
    assign query_en_next  = (state_next == QWAIT);
    assign query_cmd_next = (state_next == QWAIT) ? qcmd_next : CMD_IDLE;

    assign sent_next = (pop && sent_reg != '1) ? sent_reg + CNT_SIZE'(1) : sent_reg;
    assign drop_sum  = {1'b0, drop_reg} + (CNT_SIZE + 1)'(n_drop);
    assign drop_next = drop_sum[CNT_SIZE] ? '1 : drop_sum[CNT_SIZE-1:0];

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= RUN;
            qcmd_reg      <= CMD_IDLE;
            ev_cnt_reg    <= '0;
            count_reg     <= '0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            epoch_reg     <= '0;
            sent_reg      <= '0;
            drop_reg      <= '0;
            out_addr_reg  <= '0;
            out_valid_reg <= 1'b0;
            query_en_reg  <= 1'b0;
            query_cmd_reg <= CMD_IDLE;
        end else begin
            state_reg     <= state_next;
            qcmd_reg      <= qcmd_next;
            ev_cnt_reg    <= ev_cnt_next;
            count_reg     <= count_next;
            rd_ptr_reg    <= rd_ptr_next;
            wr_ptr_reg    <= wr_ptr_next;
            epoch_reg     <= epoch_next;
            sent_reg      <= sent_next;
            drop_reg      <= drop_next;
            out_addr_reg  <= out_addr_next;
            out_valid_reg <= out_valid_next;
            query_en_reg  <= query_en_next;
            query_cmd_reg <= query_cmd_next;
        end
    end

    // Storage array carries no reset; occupancy is tracked by count_reg.
    always_ff @(posedge clk) begin
        if (n_push != 2'd0) begin
            mem[wr_base] <= push_data0;
        end
        if (n_push == 2'd2) begin
            mem[wr_base_p1] <= push_data1;
        end
    end

    assign out_addr      = out_addr_reg;
    assign out_valid     = out_valid_reg;
    assign query_en      = query_en_reg;
    assign query_cmd     = query_cmd_reg;
    assign stat_sent_cnt = sent_reg;
    assign stat_drop_cnt = drop_reg;

endmodule
